alu_shift_stage: RTL and testbench

Registered execute-stage shift unit for the processor ALU path. Accepts an operand, 5-bit shift amount and shift opcode over a valid/ready handshake and computes SLL, SRL or SRA with a 32-bit barrel shift. Returns the result two cycles later over a second valid/ready handshake. Sits between the operand-issue logic and the ALU result writeback mux, and keeps a running count of completed operations for debug.

---
 rtl/alu_shift_stage_if.sv | 27 ++
 rtl/alu_shift_stage.sv | 107 ++++++++++
 tb/tb_alu_shift_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_stage_if.sv
// rtl/alu_shift_stage_if.sv - request/result handshake bundle for the shift stage
interface alu_shift_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [4:0]       in_shamt;
  logic [4:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_tag;

  // Issue logic and writeback consumer side
  modport master (
    output in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  // Shift stage side
  modport slave (
    input  in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_shift_stage.sv
// rtl/alu_shift_stage.sv - two-entry registered SLL/SRL/SRA execute stage
module alu_shift_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_shift_stage_if.slave     bus,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_SRL  = 2'b11;

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [4:0]       r_s1_shamt;
  logic [4:0]       r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic [4:0]       r_s2_tag;

  logic [CNT_W-1:0] r_op_count;

  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_hs;
  logic [WIDTH-1:0] w_shift;

  // s1 moves into s2 whenever s2 is empty or emptying this cycle
  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || bus.out_ready);
  // Depends only on state and out_ready, never on in_valid
  assign w_in_ready = !r_s1_valid || !r_s2_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_hs   = r_s2_valid && bus.out_ready;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_tag    = r_s2_tag;
  assign op_count       = r_op_count;

  // Barrel shift of the issued operand; shamt 0 naturally returns A
  always_comb begin
    w_shift = r_s1_a;
    case (r_s1_op)
      OP_PASS: w_shift = r_s1_a;
      OP_SLL:  w_shift = r_s1_a << r_s1_shamt;
      OP_SRA:  w_shift = $signed(r_s1_a) >>> r_s1_shamt;
      OP_SRL:  w_shift = r_s1_a >> r_s1_shamt;
      default: w_shift = r_s1_a;
    endcase
  end

  // Issue register: captures a request on an accepting edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 2'b00;
      r_s1_a     <= '0;
      r_s1_shamt <= 5'd0;
      r_s1_tag   <= 5'd0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= bus.in_op;
        r_s1_a     <= bus.in_a;
        r_s1_shamt <= bus.in_shamt;
        r_s1_tag   <= bus.in_tag;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Result register: holds steady while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= 5'd0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_shift;
        r_s2_tag    <= r_s1_tag;
      end else if (w_out_hs) begin
        r_s2_valid  <= 1'b0;
      end
    end
  end

  // Debug count of consumed results, wrapping naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count <= '0;
    end else if (w_out_hs) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_shift_stage.sv
// tb/tb_alu_shift_stage.sv - randomized scoreboard bench for alu_shift_stage
module tb_alu_shift_stage;

  logic        clock;
  logic        reset_n;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  alu_shift_stage_if bus ();
  alu_shift_stage_if bus4 ();

  alu_shift_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .op_count(op_count)
  );

  // Narrow-counter copy sees exactly the same traffic as the main instance
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_op     = bus.in_op;
  assign bus4.in_a      = bus.in_a;
  assign bus4.in_shamt  = bus.in_shamt;
  assign bus4.in_tag    = bus.in_tag;
  assign bus4.out_ready = bus.out_ready;

  alu_shift_stage #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .bus(bus4), .op_count(op_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  logic [31:0] q_res [$];
  logic [4:0]  q_tag [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Shift semantics as integer arithmetic: multiply / floor-divide by 2^shamt
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input int sh);
    longint unsigned p;
    longint unsigned u;
    longint          v;
    p = 64'd1;
    for (int i = 0; i < sh; i++) p = p * 2;
    u = {32'd0, a};
    v = longint'($signed(a));
    case (op)
      2'b01:   begin u = (u * p) % 64'h1_0000_0000; return u[31:0]; end
      2'b10:   begin
                 if (v >= 0) v = v / longint'(p);
                 else        v = -((-v + longint'(p) - 1) / longint'(p));
                 return v[31:0];
               end
      2'b11:   begin u = u / p; return u[31:0]; end
      default: return a;
    endcase
  endfunction

  // One clock: observe handshakes mid-cycle, then advance past the edge
  task automatic step();
    logic acc, hs;
    @(negedge clock);
    acc = bus.in_valid && bus.in_ready;
    hs  = bus.out_valid && bus.out_ready;
    if (prev_stall && bus.out_valid) begin
      check("stall_hold_result", bus.out_result, prev_res);
      check("stall_hold_tag", bus.out_tag, prev_tag);
    end
    if (hs) begin
      if (q_res.size() == 0) begin
        check("spurious_result", 1, 0);
      end else begin
        check("sb_result", bus.out_result, q_res.pop_front());
        check("sb_tag", bus.out_tag, q_tag.pop_front());
      end
      hs_cnt++;
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_res   = bus.out_result;
    prev_tag   = bus.out_tag;
    if (acc) begin
      q_res.push_back(ref_shift(bus.in_op, bus.in_a, int'(bus.in_shamt)));
      q_tag.push_back(bus.in_tag);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_req();
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_a     = $urandom;
    bus.in_shamt = 5'($urandom_range(0, 31));
    bus.in_tag   = 5'($urandom_range(0, 31));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    q_res.delete();
    q_tag.delete();
    hs_cnt = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int guard;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while ((q_res.size() != 0 || bus.out_valid) && guard < 50) begin
      step();
      guard++;
    end
    check({name, "_drain_empty"}, q_res.size(), 0);
    check({name, "_drain_outvalid"}, bus.out_valid, 0);
  endtask

  logic [1:0]  t_op  [9] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [31:0] t_a   [9] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFF0,
                             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
  logic [4:0]  t_sh  [9] = '{5'd31, 5'd31, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
  logic [31:0] t_exp [9] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h07FF_FFFF,
                             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 32'd0;
    bus.in_shamt  = 5'd0;
    bus.in_tag    = 5'd0;
    bus.out_ready = 1'b0;

    // Reset values and first cycle after release
    apply_reset();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_op_count", op_count, 0);

    // Directed shifts with latency and tag checks
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = t_op[i];
      bus.in_a     = t_a[i];
      bus.in_shamt = t_sh[i];
      bus.in_tag   = 5'(i + 3);
      step();
      bus.in_valid = 1'b0;
      check("lat_edge_n_outvalid", bus.out_valid, 0);
      step();
      check("lat_edge_n1_outvalid", bus.out_valid, 1);
      check($sformatf("basic_result_%0d", i), bus.out_result, t_exp[i]);
      check($sformatf("basic_tag_%0d", i), bus.out_tag, i + 3);
      step();
      check("basic_consumed", bus.out_valid, 0);
    end
    check("basic_op_count", op_count, 9);

    // Back-to-back streaming
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      randomize_req();
      check("stream_in_ready", bus.in_ready, 1);
      step();
      if (i >= 1) check("stream_no_bubble", bus.out_valid, 1);
    end
    drain("stream");
    check("stream_hs", hs_cnt, 100);
    check("stream_op_count", op_count, 100);

    // Backpressure: two entries fit, third waits
    apply_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    randomize_req();
    step();
    randomize_req();
    step();
    check("bp_queued", q_res.size(), 2);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_head_valid", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      randomize_req();
      step();
      check("bp_in_ready_held", bus.in_ready, 0);
    end
    check("bp_still_two", q_res.size(), 2);
    randomize_req();
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    drain("bp");
    check("bp_hs", hs_cnt, 3);
    check("bp_op_count", op_count, 3);

    // Counter wrap on the narrow instance
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      randomize_req();
      step();
    end
    drain("wrap");
    check("wrap_hs", hs_cnt, 17);
    check("wrap_op_count16", op_count, 17);
    check("wrap_op_count4", op_count4, 1);

    // Random stalls
    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      randomize_req();
      step();
    end
    drain("rand");
    check("rand_op_count", op_count, 16'(hs_cnt));
    check("rand_op_count4", op_count4, 4'(hs_cnt));

    // Asynchronous reset mid-cycle with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    randomize_req();
    step();
    step();
    bus.in_valid = 1'b0;
    check("full_before_reset", bus.in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_out_result", bus.out_result, 0);
    check("async_rst_out_tag", bus.out_tag, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    check("async_rst_op_count", op_count, 0);
    q_res.delete();
    q_tag.delete();
    hs_cnt = 0;
    prev_stall = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_in_ready", bus.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
